lr_car_detector: RTL
====================

# lr_car_detector

Upstream conditioning stage for the traffic light controller's local-road input. It synchronises and debounces the raw local-road loop-sensor signal, counts cars waiting at the local-road stop line, and decrements that count as cars leave on green. It drives the controller's `lr_has_car` level. It consumes the controller's `lr_light` output to know when cars are departing.

## Interface
Parameters:
- `DEBOUNCE_CYC`, 4: consecutive stable synchronised samples required before the debounced level changes; legal range 1..15.
- `PASS_CYC`, 2: green cycles needed for one queued car to depart; legal range 1..15.
- `MAX_CARS`, 7: queue count saturation value; `CW = $clog2(MAX_CARS+1)`.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sensor_raw` in 1: raw loop sensor, asynchronous to `clk`, may bounce.
- `lr_light` in 3: controller's local-road light, encoded per the shared light constants.
- `lr_has_car` out 1: high while `car_count != 0`; feeds the controller.
- `car_count` out CW: cars currently queued.
- `sensor_db` out 1: debounced sensor level.
- `overflow` out 1: sticky; set when an arrival occurs while `car_count == MAX_CARS`.

## Operation
- Synchroniser: 2-flop chain on `sensor_raw`; its output is `sync_q`.
- Debounce FSM has four states: `LOW`, `CHK_HIGH`, `HIGH`, `CHK_LOW`. An internal stability counter `stab` counts stable samples.
  - In `LOW`, `sync_q = 1` moves to `CHK_HIGH` with `stab = 1`.
  - In `CHK_HIGH`:
    - `sync_q = 0` returns to `LOW`.
    - Otherwise `stab` increments.
    - The edge on which `stab` would reach `DEBOUNCE_CYC` moves to `HIGH` and sets `sensor_db = 1`.
  - `HIGH` and `CHK_LOW` mirror this behaviour for falling.
  - `DEBOUNCE_CYC = 1` transitions directly from `LOW` to `HIGH` without a `CHK_HIGH` dwell.
- Arrival: a `sensor_db` 0→1 transition is one arrival, registered on the same edge `sensor_db` rises. Falling transitions never count.
- Departure timer `pass_t`:
  - Increments each cycle that `lr_light == LIGHT_GREEN` and `car_count != 0`.
  - When it reaches `PASS_CYC`, one departure fires and `pass_t` clears.
  - Cleared whenever the light is not green or `car_count == 0`.
- Count update, one rule per edge:
  - Arrival only: +1, saturating at `MAX_CARS`. An arrival at `MAX_CARS` sets `overflow` instead.
  - Departure only: −1. It never fires at 0.
  - Arrival and departure on the same edge: count unchanged. This case never sets `overflow`.
- `lr_has_car` is registered and equals `car_count != 0` after each edge, so both update on the same edge.
- `overflow` clears only on `rst`.

## Timing
- Reset values: FSM `LOW`, `stab = 0`, `pass_t = 0`, sync flops 0, `sensor_db = 0`, `car_count = 0`, `lr_has_car = 0`, `overflow = 0`.
- Reset asserted mid-operation discards the queue and any in-progress debounce on the next edge. There is no partial state.
- Sensor-to-count latency: `sensor_raw` high, held stable and sampled at edge k, gives `sensor_db = 1`, `car_count + 1` and `lr_has_car = 1` after edge k+1+`DEBOUNCE_CYC` (edge k+5 with defaults).
- A bounce, meaning `sync_q` reverting before `DEBOUNCE_CYC` stable samples, produces no arrival and no change on `sensor_db`.
- Departure latency: with the count non-zero and green asserted from edge j, the first decrement lands after edge j+`PASS_CYC`−1. Subsequent decrements follow every `PASS_CYC` edges while green persists.
- When the light leaves green mid-pass, the partial `pass_t` progress is lost. The next green restarts the full `PASS_CYC`.
- `lr_light` is consumed as a registered controller output; no extra synchronisation.

## Structure
- Shared package `traffic_pkg`:
  - Light encodings `LIGHT_GREEN = 3'b100`, `LIGHT_YELLOW = 3'b010`, `LIGHT_RED = 3'b001`; the controller uses the same constants.
  - Debounce state constants `DB_LOW`, `DB_CHK_HIGH`, `DB_HIGH`, `DB_CHK_LOW`, 2-bit.
- One sub-module, `sensor_debounce`, containing the synchroniser, debounce FSM and `stab`. Its outputs are `sensor_db` and a one-cycle `arrive` pulse.
- The top `lr_car_detector` holds `pass_t`, `car_count`, `overflow` and `lr_has_car`.

## Test plan
- Clean arrival: with defaults, raise `sensor_raw` at edge 10 and hold it for 20 cycles. Required response: `sensor_db`, `car_count = 1` and `lr_has_car = 1` after edge 15. Dropping the sensor leaves the count at 1.
- Bounce rejection: toggle `sensor_raw` high for 3 cycles and low for 1, repeated 5 times, then hold it low. Required response: `car_count = 0`, `sensor_db = 0` throughout.
- Drain on green: queue 3 cars, then hold `lr_light = 3'b100` from edge j. Required response: count steps 3→2→1→0 after edges j+1, j+3, j+5; `lr_has_car` falls with the last step.
- Green interruption: with 2 cars queued, apply green for 1 cycle, red for 3, then green again. Required response: no decrement from the first green; the first decrement comes one full `PASS_CYC` after green returns.
- Saturation: generate 9 clean arrivals with the light red. Required response: `car_count` holds at 7 and `overflow = 1`. Applying `rst` for one cycle clears everything to 0.
- Simultaneous events: time an arrival to land on the same edge as a departure with the count at 2. Required response: count stays 2 and `overflow` stays 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light controller and its input stages.
// Light codes are one-hot; debounce states are 2-bit.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

  typedef enum logic [1:0] {
    DB_LOW      = 2'd0,
    DB_CHK_HIGH = 2'd1,
    DB_HIGH     = 2'd2,
    DB_CHK_LOW  = 2'd3
  } db_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Loop-sensor synchroniser and debounce FSM.
// arrive is combinational: high in the cycle whose edge raises sensor_db.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  output logic sensor_db,
  output logic arrive
);

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_CYC);

  logic      s1, sync_q;
  db_state_t state, state_n;
  logic [3:0] stab, stab_n, stab_inc;
  logic      db_n;

  assign stab_inc = stab + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      sync_q    <= 1'b0;
      state     <= DB_LOW;
      stab      <= 4'd0;
      sensor_db <= 1'b0;
    end else begin
      s1        <= sensor_raw;
      sync_q    <= s1;
      state     <= state_n;
      stab      <= stab_n;
      sensor_db <= db_n;
    end
  end

  always_comb begin
    state_n = state;
    stab_n  = stab;
    db_n    = sensor_db;
    arrive  = 1'b0;
    unique case (state)
      DB_LOW: begin
        if (sync_q) begin
          if (DB_N == 4'd1) begin
            state_n = DB_HIGH;
            stab_n  = 4'd0;
            db_n    = 1'b1;
            arrive  = 1'b1;
          end else begin
            state_n = DB_CHK_HIGH;
            stab_n  = 4'd1;
          end
        end
      end
      DB_CHK_HIGH: begin
        if (!sync_q) begin
          state_n = DB_LOW;
          stab_n  = 4'd0;
        end else if (stab_inc == DB_N) begin
          state_n = DB_HIGH;
          stab_n  = 4'd0;
          db_n    = 1'b1;
          arrive  = 1'b1;
        end else begin
          stab_n = stab_inc;
        end
      end
      DB_HIGH: begin
        if (!sync_q) begin
          if (DB_N == 4'd1) begin
            state_n = DB_LOW;
            stab_n  = 4'd0;
            db_n    = 1'b0;
          end else begin
            state_n = DB_CHK_LOW;
            stab_n  = 4'd1;
          end
        end
      end
      DB_CHK_LOW: begin
        if (sync_q) begin
          state_n = DB_HIGH;
          stab_n  = 4'd0;
        end else if (stab_inc == DB_N) begin
          state_n = DB_LOW;
          stab_n  = 4'd0;
          db_n    = 1'b0;
        end else begin
          stab_n = stab_inc;
        end
      end
    endcase
  end

endmodule

// File: rtl/lr_car_detector.sv
// Local-road car queue: counts debounced arrivals, drains on green.
// Simultaneous arrival and departure cancel out.
module lr_car_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int PASS_CYC     = 2,
  parameter int MAX_CARS     = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sensor_raw,
  input  logic [2:0]                       lr_light,
  output logic                             lr_has_car,
  output logic [$clog2(MAX_CARS+1)-1:0]    car_count,
  output logic                             sensor_db,
  output logic                             overflow
);

  localparam int         CW     = $clog2(MAX_CARS + 1);
  localparam logic [3:0] PASS_N = 4'(PASS_CYC);
  localparam logic [CW-1:0] MAX_N = CW'(MAX_CARS);

  logic          arrive, depart, green, busy, at_max;
  logic [3:0]    pass_t, pass_n, pass_inc;
  logic [CW-1:0] count_n;
  logic          ovf_n;

  sensor_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db (
    .clk       (clk),
    .rst       (rst),
    .sensor_raw(sensor_raw),
    .sensor_db (sensor_db),
    .arrive    (arrive)
  );

  assign green    = lr_light == LIGHT_GREEN;
  assign busy     = car_count != '0;
  assign at_max   = car_count == MAX_N;
  assign pass_inc = pass_t + 4'd1;
  assign depart   = green && busy && pass_inc == PASS_N;

  always_comb begin
    pass_n  = pass_inc;
    count_n = car_count;
    ovf_n   = overflow;
    if (!green || !busy || depart) pass_n = 4'd0;
    if (arrive && !depart) begin
      if (at_max) ovf_n = 1'b1;
      else        count_n = car_count + 1'b1;
    end else if (depart && !arrive) begin
      count_n = car_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_t     <= 4'd0;
      car_count  <= '0;
      overflow   <= 1'b0;
      lr_has_car <= 1'b0;
    end else begin
      pass_t     <= pass_n;
      car_count  <= count_n;
      overflow   <= ovf_n;
      lr_has_car <= count_n != '0;
    end
  end

endmodule
